// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a small byte FIFO.
//   Byte stores (wr_en/wr_data) are queued in the FIFO; an FSM drains it
//   onto tx as 8N1 frames, LSB first, back to back while bytes are waiting.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, clears all state
//   wr_en      enqueue strobe, one byte per asserted cycle
//   wr_data    byte to enqueue
//   clr_ovf    clears the sticky overflow flag
//   tx         serial output, idle high, registered
//   tx_busy    high while a frame is on the line
//   fifo_full  FIFO holds FIFO_DEPTH bytes
//   fifo_empty FIFO holds no bytes
//   fifo_count current occupancy
//   ovf        sticky: a write was dropped because the FIFO was full
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             tx_busy,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             ovf
);

    localparam int AW = CNT_W - 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_ovf;

    state_t           r_state;
    state_t           w_state_nx;
    logic [BW-1:0]    r_baud;
    logic [BW-1:0]    w_baud_nx;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nx;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nx;
    logic             r_tx;
    logic             w_tx_nx;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic             w_baud_end;
    logic [CNT_W-1:0] w_wr_nx;
    logic [CNT_W-1:0] w_rd_nx;

    // Fullness is judged on the registered flag, so a write while full is
    // dropped even if the FSM pops in the same cycle.
    always_comb begin
        w_push  = wr_en & ~r_full;
        w_wr_nx = r_wr_ptr + CNT_W'(w_push);
        w_rd_nx = r_rd_ptr + CNT_W'(w_pop);
    end

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        w_baud_end = (r_baud == BAUD_LAST);
        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (!r_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rd_ptr[AW-1:0]];
                    w_baud_nx  = '0;
                    w_idx_nx   = '0;
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nx  = '0;
                    w_idx_nx   = '0;
                    w_tx_nx    = r_shift[0];
                    w_state_nx = S_DATA;
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    if (r_idx == 3'd7) begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                        w_tx_nx  = r_shift[r_idx + 3'd1];
                    end
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!r_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = r_mem[r_rd_ptr[AW-1:0]];
                        w_idx_nx   = '0;
                        w_tx_nx    = 1'b0;
                        w_state_nx = S_START;
                    end else begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_baud   <= w_baud_nx;
            r_idx    <= w_idx_nx;
            r_shift  <= w_shift_nx;
            r_tx     <= w_tx_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_wr_ptr <= w_wr_nx;
            r_rd_ptr <= w_rd_nx;
            r_count  <= w_wr_nx - w_rd_nx;
            // Pointers carry an extra MSB: equal means empty, differing
            // only in the MSB means full.
            r_full   <= ((w_wr_nx ^ w_rd_nx) == {1'b1, {AW{1'b0}}});
            r_empty  <= (w_wr_nx == w_rd_nx);
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        tx         = r_tx;
        tx_busy    = r_busy;
        fifo_full  = r_full;
        fifo_empty = r_empty;
        fifo_count = r_count;
        ovf        = r_ovf;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a fast baud rate.
// Accepted bytes are queued when written; a serial receiver decodes tx
// frames and compares them against the queue in order.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          tx;
    logic          tx_busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          rx_en = 1'b0;
    logic [7:0]    rx_byte;
    logic [7:0]    exp_byte;
    logic [7:0]    sb [$];
    int            starts [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the next negedge with wr_en low.
    task automatic write_byte(input logic [7:0] d, input logic accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) sb.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (CPB + 2) @(negedge clk);
    endtask

    // Serial receiver: detects the first low cycle of a start bit, samples
    // each bit mid-period, and compares the byte against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && !reset && tx == 1'b0) begin
                starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                check("rx_start", tx, 0);
                check("rx_busy", tx_busy, 1);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("rx_stop", tx, 1);
                check("rx_stop_busy", tx_busy, 1);
                check("rx_sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_byte = sb.pop_front();
                    check("rx_byte", rx_byte, exp_byte);
                end
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
            end
        end
    end

    initial begin
        int sent;
        int guard;
        int bad;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", ovf, 0);
        rx_en = 1'b1;
        @(negedge clk);

        // Single frame of 0x55
        write_byte(8'h55, 1'b1);
        check("t1_empty", fifo_empty, 0);
        check("t1_count", fifo_count, 1);
        check("t1_tx_idle", tx, 1);
        @(negedge clk);
        check("t1_tx_start", tx, 0);
        check("t1_busy", tx_busy, 1);
        check("t1_empty_after_pop", fifo_empty, 1);
        wait_drain(200);
        check("t1_idle_busy", tx_busy, 0);
        check("t1_idle_tx", tx, 1);

        // Three bytes on consecutive cycles, frames back to back
        starts.delete();
        write_byte(8'hA5, 1'b1);
        write_byte(8'h3C, 1'b1);
        write_byte(8'hFF, 1'b1);
        check("t2_peak_count", fifo_count, 2);
        wait_drain(400);
        check("t2_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("t2_gap01", starts[1] - starts[0], 10 * CPB);
            check("t2_gap12", starts[2] - starts[1], 10 * CPB);
        end
        check("t2_busy", tx_busy, 0);

        // Overflow while the first frame is on the line
        write_byte(8'h11, 1'b1);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(8'h20 + 8'(i), 1'b1);
        end
        check("t3_full", fifo_full, 1);
        check("t3_count16", fifo_count, DEPTH);
        check("t3_ovf_before", ovf, 0);
        write_byte(8'h99, 1'b0);
        check("t3_ovf_set", ovf, 1);
        check("t3_count_hold", fifo_count, DEPTH);
        // Write and clear together while still full: set wins
        wr_en   = 1'b1;
        wr_data = 8'h77;
        clr_ovf = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check("t6_ovf_priority", ovf, 1);
        check("t6_count", fifo_count, DEPTH);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t3_ovf_clr", ovf, 0);
        wait_drain(1000);

        // Reset during DATA bit 3 of 0x0F with two bytes queued
        rx_en = 1'b0;
        write_byte(8'h0F, 1'b0);
        write_byte(8'hAA, 1'b0);
        write_byte(8'hBB, 1'b0);
        check("t4_queued", fifo_count, 2);
        repeat (16) @(negedge clk);
        check("t4_bit3", tx, 1);
        check("t4_busy_pre", tx_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_tx", tx, 1);
        check("t4_empty", fifo_empty, 1);
        check("t4_count", fifo_count, 0);
        check("t4_busy", tx_busy, 0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("t4_no_frames", bad, 0);
        rx_en = 1'b1;

        // Flow-controlled stream of 40 bytes, pointers wrap twice
        sent  = 0;
        guard = 0;
        while (sent < 40 && guard < 5000) begin
            if (!fifo_full) begin
                wr_en   = 1'b1;
                wr_data = 8'(sent);
                sb.push_back(8'(sent));
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        wr_en = 1'b0;
        check("t5_sent", sent, 40);
        wait_drain(2500);
        check("t5_ovf", ovf, 0);
        check("t5_empty", fifo_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
